// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction-field positions and default widths.
package sisc_pkg;

    localparam int PC_W_DEF    = 16;
    localparam int INSTR_W_DEF = 32;

    typedef enum logic [3:0] {
        NOOP   = 4'd0,
        REG_OP = 4'd1,
        REG_IM = 4'd2,
        SWAP   = 4'd3,
        BRA    = 4'd4,
        BRR    = 4'd5,
        BNE    = 4'd6,
        BNR    = 4'd7,
        JPA    = 4'd8,
        JPR    = 4'd9,
        LOD    = 4'd10,
        STR    = 4'd11,
        CALL   = 4'd12,
        RET    = 4'd13,
        HLT    = 4'd15
    } opcode_e;

    // Low bit of each 4-bit field in the instruction word; imm sits at bit 0.
    localparam int FIELD_W    = 4;
    localparam int OPCODE_LSB = 28;
    localparam int MM_LSB     = 24;
    localparam int RS_LSB     = 20;
    localparam int RT_LSB     = 16;
    localparam int RD_LSB     = 12;

endpackage

// File: rtl/pc_ir_unit_if.sv
// Control strobes, status, instruction-memory bus and decoded fields of the PC/IR stage.
interface pc_ir_unit_if #(
    parameter int PC_W    = sisc_pkg::PC_W_DEF,
    parameter int INSTR_W = sisc_pkg::INSTR_W_DEF
);
    logic               pc_rst;
    logic               pc_write;
    logic               pc_sel;
    logic               br_sel;
    logic               ir_load;
    logic [3:0]         stat;
    logic [INSTR_W-1:0] imem_data;
    logic [PC_W-1:0]    imem_addr;
    logic [3:0]         opcode;
    logic [3:0]         mm;
    logic [3:0]         rs;
    logic [3:0]         rt;
    logic [3:0]         rd;
    logic [PC_W-1:0]    imm;
    logic               br_taken;
    logic [15:0]        instr_cnt;

    modport master (
        output pc_rst, pc_write, pc_sel, br_sel, ir_load, stat, imem_data,
        input  imem_addr, opcode, mm, rs, rt, rd, imm, br_taken, instr_cnt
    );

    modport slave (
        input  pc_rst, pc_write, pc_sel, br_sel, ir_load, stat, imem_data,
        output imem_addr, opcode, mm, rs, rt, rd, imm, br_taken, instr_cnt
    );
endinterface

// File: rtl/pc_ir_unit_br_cond.sv
// Branch-condition evaluator: masks the status CCs with mm and tests per branch opcode.
module br_cond
    import sisc_pkg::*;
(
    input  logic [3:0] opcode,
    input  logic [3:0] mm,
    input  logic [3:0] stat,
    output logic       cond
);

    always_comb begin
        // NOTE: default first so every path assigns cond and no latch is inferred.
        cond = 1'b0;
        case (opcode_e'(opcode))
            BRA, BRR: cond = |(stat & mm);
            BNE, BNR: cond = ~|(stat & mm);
            default:  cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/pc_ir_unit.sv
// SISC program counter and instruction register: fetch addressing, IR latch, field split,
// branch resolution and a retired-fetch counter.
module pc_ir_unit
    import sisc_pkg::*;
#(
    parameter int PC_W    = PC_W_DEF,
    parameter int INSTR_W = INSTR_W_DEF
) (
    input  logic         clk,
    input  logic         rst_f,
    pc_ir_unit_if.slave  bus
);

    logic [PC_W-1:0]    pc;
    logic [INSTR_W-1:0] ir;
    logic               br_taken;
    logic [15:0]        instr_cnt;
    logic [PC_W-1:0]    imm;
    logic [PC_W-1:0]    target;
    logic               cond;
    logic               branch;

    assign imm    = ir[PC_W-1:0];
    assign branch = bus.pc_write & bus.pc_sel;
    // Relative targets are taken from the already-incremented PC.
    assign target = bus.br_sel ? imm : pc + imm;

    br_cond u_br_cond (
        .opcode (ir[OPCODE_LSB +: FIELD_W]),
        .mm     (ir[MM_LSB +: FIELD_W]),
        .stat   (bus.stat),
        .cond   (cond)
    );

    always_ff @(posedge clk or negedge rst_f) begin
        if (!rst_f) begin
            pc        <= '0;
            ir        <= '0;
            br_taken  <= 1'b0;
            instr_cnt <= '0;
        end else begin
            // NOTE: non-blocking so every register samples the pre-edge pc/ir,
            // letting a fetch and a branch in one cycle both see the old state.
            if (bus.pc_rst)
                pc <= '0;
            else if (bus.pc_write && !bus.pc_sel)
                pc <= pc + 1'b1;
            else if (branch && cond)
                pc <= target;

            if (bus.ir_load) begin
                ir        <= bus.imem_data;
                instr_cnt <= instr_cnt + 16'd1;
            end

            if (bus.pc_rst)
                br_taken <= 1'b0;
            else if (branch)
                br_taken <= cond;
            else if (bus.ir_load)
                br_taken <= 1'b0;
        end
    end

    assign bus.imem_addr = pc;
    assign bus.opcode    = ir[OPCODE_LSB +: FIELD_W];
    assign bus.mm        = ir[MM_LSB +: FIELD_W];
    assign bus.rs        = ir[RS_LSB +: FIELD_W];
    assign bus.rt        = ir[RT_LSB +: FIELD_W];
    assign bus.rd        = ir[RD_LSB +: FIELD_W];
    assign bus.imm       = imm;
    assign bus.br_taken  = br_taken;
    assign bus.instr_cnt = instr_cnt;

endmodule

// File: tb/tb_pc_ir_unit.sv
// Self-checking bench for pc_ir_unit: directed scenarios then random strobes against a
// behavioural model of the PC/IR rules.
module tb_pc_ir_unit;

    logic clk = 1'b0;
    logic rst_f = 1'b0;
    int   checks = 0;
    int   passed = 0;

    logic [31:0] mem [256];

    // Reference model state
    logic [15:0] m_pc;
    logic [31:0] m_ir;
    logic        m_bt;
    logic [15:0] m_cnt;

    pc_ir_unit_if #(.PC_W(16), .INSTR_W(32)) bif ();

    pc_ir_unit #(.PC_W(16), .INSTR_W(32)) dut (
        .clk   (clk),
        .rst_f (rst_f),
        .bus   (bif)
    );

    always #5 clk = ~clk;

    assign bif.imem_data = mem[bif.imem_addr[7:0]];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    endtask

    task automatic check_all(input string tag);
        check({tag, ".imem_addr"}, 32'(bif.imem_addr), 32'(m_pc));
        check({tag, ".opcode"},    32'(bif.opcode),    32'(m_ir >> 28));
        check({tag, ".mm"},        32'(bif.mm),        32'((m_ir >> 24) % 16));
        check({tag, ".rs"},        32'(bif.rs),        32'((m_ir >> 20) % 16));
        check({tag, ".rt"},        32'(bif.rt),        32'((m_ir >> 16) % 16));
        check({tag, ".rd"},        32'(bif.rd),        32'((m_ir >> 12) % 16));
        check({tag, ".imm"},       32'(bif.imm),       32'(m_ir % 65536));
        check({tag, ".br_taken"},  32'(bif.br_taken),  32'(m_bt));
        check({tag, ".instr_cnt"}, 32'(bif.instr_cnt), 32'(m_cnt));
    endtask

    task automatic model_reset();
        m_pc  = '0;
        m_ir  = '0;
        m_bt  = 1'b0;
        m_cnt = '0;
    endtask

    // One clock cycle: drive strobes, predict from the spec rules, compare after the edge.
    task automatic step(input string tag, input bit pr, input bit pw, input bit ps,
                        input bit bs, input bit il, input logic [3:0] st);
        int op, mask, imm, tgt, npc, ncnt;
        bit c, nbt;
        logic [31:0] nir;
        @(negedge clk);
        bif.pc_rst   = pr;
        bif.pc_write = pw;
        bif.pc_sel   = ps;
        bif.br_sel   = bs;
        bif.ir_load  = il;
        bif.stat     = st;

        op   = int'(m_ir >> 28);
        mask = int'(st) & int'((m_ir >> 24) % 16);
        imm  = int'(m_ir % 65536);
        if (op == 4 || op == 5)      c = (mask != 0);
        else if (op == 6 || op == 7) c = (mask == 0);
        else                         c = 1'b0;
        tgt = bs ? imm : (int'(m_pc) + imm) % 65536;

        npc = int'(m_pc);
        if (pr)                 npc = 0;
        else if (pw && !ps)     npc = (int'(m_pc) + 1) % 65536;
        else if (pw && ps && c) npc = tgt;

        nir  = il ? mem[m_pc[7:0]] : m_ir;
        ncnt = il ? (int'(m_cnt) + 1) % 65536 : int'(m_cnt);

        nbt = m_bt;
        if (pr)           nbt = 1'b0;
        else if (pw && ps) nbt = c;
        else if (il)      nbt = 1'b0;

        @(posedge clk);
        #1;
        m_pc  = 16'(npc);
        m_ir  = nir;
        m_bt  = nbt;
        m_cnt = 16'(ncnt);
        check_all(tag);
    endtask

    initial begin
        logic [15:0] cnt_before;
        bif.pc_rst   = 1'b0;
        bif.pc_write = 1'b0;
        bif.pc_sel   = 1'b0;
        bif.br_sel   = 1'b0;
        bif.ir_load  = 1'b0;
        bif.stat     = 4'h0;
        for (int i = 0; i < 256; i++) mem[i] = $urandom;
        model_reset();

        // Reset state while rst_f is held low
        #12;
        check_all("reset");
        @(negedge clk);
        rst_f = 1'b1;

        // Three fetches: opcode 1, 2, 4 with PC stepping 0 -> 3
        mem[0] = 32'h1012_3456;
        mem[1] = 32'h2034_5678;
        mem[2] = 32'h4056_789A;
        step("fetch0", 0, 1, 0, 0, 1, 4'h0);
        check("fetch0_addr", 32'(bif.imem_addr), 32'd1);
        check("fetch0_op",   32'(bif.opcode),    32'd1);
        step("fetch1", 0, 1, 0, 0, 1, 4'h0);
        check("fetch1_op",   32'(bif.opcode),    32'd2);
        step("fetch2", 0, 1, 0, 0, 1, 4'h0);
        check("fetch2_addr", 32'(bif.imem_addr), 32'd3);
        check("fetch2_op",   32'(bif.opcode),    32'd4);
        check("fetch2_cnt",  32'(bif.instr_cnt), 32'd3);

        // BRR relative, taken: 0x0003 + 0x0010
        mem[3] = 32'h5200_0010;
        step("load_brr", 0, 0, 0, 0, 1, 4'h0);
        step("brr_taken", 0, 1, 1, 0, 0, 4'h2);
        check("brr_pc", 32'(bif.imem_addr), 32'h13);
        check("brr_bt", 32'(bif.br_taken),  32'd1);

        // BNE absolute: not taken with stat=1, taken with stat=0
        step("clr0", 1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) step("inc", 0, 1, 0, 0, 0, 4'h0);
        mem[3] = 32'h6100_0040;
        step("load_bne", 0, 0, 0, 0, 1, 4'h0);
        step("bne_nt", 0, 1, 1, 1, 0, 4'h1);
        check("bne_nt_pc", 32'(bif.imem_addr), 32'h3);
        check("bne_nt_bt", 32'(bif.br_taken),  32'd0);
        step("bne_t", 0, 1, 1, 1, 0, 4'h0);
        check("bne_t_pc", 32'(bif.imem_addr), 32'h40);
        check("bne_t_bt", 32'(bif.br_taken),  32'd1);

        // Jump to 0xFFFF then increment wraps to 0
        mem[8'h40] = 32'h6000_FFFF;
        step("load_ffff", 0, 0, 0, 0, 1, 4'h0);
        step("jmp_ffff", 0, 1, 1, 1, 0, 4'h5);
        check("pc_ffff", 32'(bif.imem_addr), 32'hFFFF);
        step("wrap", 0, 1, 0, 0, 0, 4'h0);
        check("pc_wrap", 32'(bif.imem_addr), 32'h0);

        // BRR with imm=0xFFFE from pc=1 lands on 0xFFFF
        mem[0] = 32'h5F00_FFFE;
        step("fetch_brr", 0, 1, 0, 0, 1, 4'h0);
        step("brr_neg", 0, 1, 1, 0, 0, 4'h1);
        check("brr_neg_pc", 32'(bif.imem_addr), 32'hFFFF);

        // pc_rst with pc_write and ir_load at pc=7
        step("clr1", 1, 0, 0, 0, 0, 4'h0);
        for (int i = 0; i < 7; i++) step("inc", 0, 1, 0, 0, 0, 4'h0);
        mem[7] = 32'hA123_4567;
        cnt_before = m_cnt;
        step("pcrst_load", 1, 1, 0, 0, 1, 4'h0);
        check("pcrst_pc",  32'(bif.imem_addr), 32'h0);
        check("pcrst_bt",  32'(bif.br_taken),  32'd0);
        check("pcrst_op",  32'(bif.opcode),    32'hA);
        check("pcrst_cnt", 32'(bif.instr_cnt), 32'(cnt_before + 16'd1));

        // Async reset mid-cycle with pc=5, strobes active while held
        step("fetch_p", 0, 1, 0, 0, 1, 4'h0);
        for (int i = 0; i < 4; i++) step("inc", 0, 1, 0, 0, 0, 4'h0);
        check("pre_rst_pc", 32'(bif.imem_addr), 32'h5);
        @(negedge clk);
        #2;
        bif.pc_write = 1'b1;
        bif.ir_load  = 1'b1;
        rst_f = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        @(posedge clk);
        #1;
        check_all("rst_hold");
        @(negedge clk);
        bif.pc_write = 1'b0;
        bif.ir_load  = 1'b0;
        rst_f = 1'b1;

        // Random strobes, with memory biased toward branch opcodes
        for (int i = 0; i < 256; i++)
            mem[i] = {($urandom_range(0, 1) == 1) ? 4'($urandom_range(4, 7)) : 4'($urandom),
                      28'($urandom)};
        for (int i = 0; i < 400; i++)
            step("rand", ($urandom_range(0, 19) == 0), 1'($urandom), 1'($urandom),
                 1'($urandom), 1'($urandom), 4'($urandom));

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
